triggered_sampler: RTL
======================

TRIGGERED_SAMPLER -- requirements
Module: triggered_sampler

Interface
REQ-001 Parameter width, default 8: sample word width in bits.
REQ-002 Parameter timeBits, default 10: log2 of buffer depth; depth = 2**timeBits.
REQ-003 clk  in  1  single clock for capture and readout.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 arm  in  1  one-cycle pulse that starts a new capture.
REQ-006 pre_count  in  timeBits  number of pre-trigger samples, sampled on arm.
REQ-007 trig_mask  in  width  bits participating in the trigger compare.
REQ-008 trig_value  in  width  compare value for masked bits.
REQ-009 trig_edge  in  1  0 = level trigger; 1 = rising-edge-of-condition trigger.
REQ-010 w_in  in  width  sample input, one sample per clk while capturing.
REQ-011 busy  out  1  high in PRE, WAIT or POST.
REQ-012 triggered  out  1  high from the trigger sample until the next arm or reset.
REQ-013 done  out  1  high in DONE.
REQ-014 done_pulse  out  1  one-cycle pulse on entry to DONE.
REQ-015 r_enable  in  1  read strobe.
REQ-016 r_addr  in  timeBits  logical read index; 0 = oldest captured sample.
REQ-017 r_out  out  width  read data.

Function
REQ-018 The FSM SHALL have the states IDLE, PRE, WAIT, POST and DONE.
REQ-019 arm SHALL latch pre_count, trig_mask, trig_value and trig_edge, clear the write pointer wp and the triggered output, and enter PRE; if the latched pre_count is 0, it SHALL enter WAIT instead.
REQ-020 arm in any state SHALL abort the current capture and restart it per REQ-019.
REQ-021 In PRE, WAIT and POST, each clk SHALL write w_in to mem[wp] and increment wp modulo depth.
REQ-022 In IDLE and DONE, no writes SHALL occur.
REQ-023 PRE SHALL write exactly pre_count samples and then enter WAIT; trigger conditions during PRE SHALL be ignored.
REQ-024 The trigger condition SHALL be cond = ((w_in ^ trig_value) & trig_mask) == 0; an all-zero mask SHALL mean an immediate trigger.
REQ-025 With trig_edge = 1, a trigger SHALL require cond now and no cond on the previous sample; the "previous" flag SHALL be cleared on arm.
REQ-026 In WAIT, the buffer SHALL wrap indefinitely.
REQ-027 On the trigger sample, the block SHALL write that sample, set triggered and latch start = (wp - pre_count) mod depth.
REQ-028 After the trigger, the block SHALL enter POST with remaining = depth - pre_count - 1; if remaining is 0, it SHALL go directly to DONE.
REQ-029 POST SHALL write remaining samples and then enter DONE; the total capture SHALL be exactly depth samples, with the trigger sample at logical index pre_count.
REQ-030 On r_enable, r_out SHALL register mem[(start + r_addr) mod depth] with 1-cycle latency; r_out SHALL hold its value otherwise.
REQ-031 Reads SHALL be permitted in any state; read data is defined only in DONE.
REQ-032 arm and reset SHALL NOT clear the memory contents.

Reset
REQ-033 reset SHALL force the FSM to IDLE and set wp = 0, start = 0, triggered = 0, done = 0, done_pulse = 0, r_out = 0 and the edge flag = 0.
REQ-034 reset mid-capture SHALL abandon the capture; a new arm is required afterwards.

Structure
REQ-035 A shared package SHALL hold the FSM state enumeration and the trigger-mode encoding.
REQ-036 The memory SHALL be a sub-module sampler_ram: a simple dual-port RAM with a synchronous registered read.
REQ-037 The FSM, counters and trigger compare SHALL live in triggered_sampler.

Verification (width = 8, timeBits = 4, depth = 16)
REQ-038 w_in = cycle count, pre_count = 4, mask = FF, value = 20, level -> done after the sample value 31; logical reads 0..15 return 16..31; triggered set.
REQ-039 pre_count = 0, mask = 00 -> immediate trigger on the first sample; 16 samples captured; done_pulse lasts exactly 1 cycle.
REQ-040 trig_edge = 1, mask = 01, value = 01, w_in bit0 held high from arm -> no trigger until bit0 has fallen and risen; the trigger sample is at index pre_count.
REQ-041 pre_count = 15 with the trigger in WAIT -> remaining = 0; DONE entered the cycle after the trigger sample; index 15 = trigger sample.
REQ-042 arm reissued mid-POST, and separately reset asserted mid-WAIT -> capture restarts and state returns to IDLE respectively; triggered = 0, done = 0 in both cases.
REQ-043 A trigger condition held true during PRE with pre_count = 6 -> trigger occurs on the 7th sample, not earlier.

Source files
------------

// File: rtl/triggered_sampler_pkg.sv
// Shared definitions for the triggered sampler.
//   state_e     : capture FSM states
//   trig_mode_e : trigger mode (level or rising edge of the match condition)
package triggered_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } trig_mode_e;

    // States in which one sample is written per clock.
    function automatic logic is_capturing(input state_e st);
        return (st == ST_PRE) || (st == ST_WAIT) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/sampler_ram.sv
// Simple dual-port sample memory with a registered, enable-held read port.
//   clk      : single clock for both ports
//   reset    : async active-high, clears only the read register
//   wr_en    : write strobe, wr_addr / wr_data : write port
//   rd_en    : read strobe, rd_addr : read address
//   rd_data  : registered read data, holds when rd_en is low
// The array itself is never reset, so captured data survives arm/reset.
module sampler_ram #(
    parameter int width    = 8,
    parameter int addrBits = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [addrBits-1:0] wr_addr,
    input  logic [width-1:0]    wr_data,
    input  logic                rd_en,
    input  logic [addrBits-1:0] rd_addr,
    output logic [width-1:0]    rd_data
);

    localparam int DEPTH = 1 << addrBits;

    logic [width-1:0] mem [DEPTH];
    logic [width-1:0] rd_data_d;
    logic [width-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/triggered_sampler.sv
// Triggered logic-analyser style sampler with pre-trigger history.
//   clk, reset            : clock, async active-high reset
//   arm                   : one-cycle pulse starting (or restarting) a capture
//   pre_count             : pre-trigger sample count, latched on arm
//   trig_mask/trig_value  : masked compare defining the trigger condition
//   trig_edge             : 0 = level, 1 = rising edge of the condition
//   w_in                  : sample stream, one sample per clk while capturing
//   busy/triggered/done   : capture status, done_pulse marks entry to DONE
//   r_enable/r_addr/r_out : readout, r_addr 0 = oldest captured sample
module triggered_sampler
    import triggered_sampler_pkg::*;
#(
    parameter int width    = 8,
    parameter int timeBits = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic [timeBits-1:0] pre_count,
    input  logic [width-1:0]    trig_mask,
    input  logic [width-1:0]    trig_value,
    input  logic                trig_edge,
    input  logic [width-1:0]    w_in,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic                done_pulse,
    input  logic                r_enable,
    input  logic [timeBits-1:0] r_addr,
    output logic [width-1:0]    r_out
);

    localparam logic [timeBits-1:0] CNT_ONE = 1;

    state_e              state_q, state_d;
    logic [timeBits-1:0] wp_q, wp_d;
    logic [timeBits-1:0] cnt_q, cnt_d;
    logic [timeBits-1:0] start_q, start_d;
    logic                prev_q, prev_d;
    logic                triggered_q, triggered_d;
    logic                done_pulse_q, done_pulse_d;

    logic [timeBits-1:0] cfg_pre_q, cfg_pre_d;
    logic [width-1:0]    cfg_mask_q, cfg_mask_d;
    logic [width-1:0]    cfg_value_q, cfg_value_d;
    trig_mode_e          cfg_mode_q, cfg_mode_d;

    logic                capturing;
    logic                cond;
    logic                hit;
    logic                wr_en;
    logic [timeBits-1:0] rd_addr;

    assign capturing = is_capturing(state_q);
    assign cond      = ((w_in ^ cfg_value_q) & cfg_mask_q) == '0;
    // Edge mode needs the condition to be false on the previously written sample.
    assign hit       = (cfg_mode_q == TRIG_EDGE) ? (cond && !prev_q) : cond;
    // arm takes priority: the arm cycle itself never writes.
    assign wr_en     = capturing && !arm;
    assign rd_addr   = start_q + r_addr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = (pre_count == '0) ? ST_WAIT : ST_PRE;
        end else begin
            case (state_q)
                ST_PRE: begin
                    if (cnt_q == CNT_ONE) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // No post samples remain when pre_count is depth-1.
                    if (hit) state_d = (cfg_pre_q == '1) ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (cnt_q == CNT_ONE) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy       = capturing;
        done       = (state_q == ST_DONE);
        triggered  = triggered_q;
        done_pulse = done_pulse_q;
    end

    // Pointers, counters and flags
    always_comb begin
        wp_d         = wp_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        prev_d       = prev_q;
        triggered_d  = triggered_q;
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        if (arm) begin
            wp_d        = '0;
            cnt_d       = pre_count;
            prev_d      = 1'b0;
            triggered_d = 1'b0;
        end else if (capturing) begin
            wp_d   = wp_q + CNT_ONE;
            prev_d = cond;
            case (state_q)
                ST_PRE:  cnt_d = cnt_q - CNT_ONE;
                ST_POST: cnt_d = cnt_q - CNT_ONE;
                ST_WAIT: begin
                    if (hit) begin
                        triggered_d = 1'b1;
                        start_d     = wp_q - cfg_pre_q;
                        // depth - pre_count - 1 is the bitwise complement modulo depth.
                        cnt_d       = ~cfg_pre_q;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q         <= '0;
            cnt_q        <= '0;
            start_q      <= '0;
            prev_q       <= 1'b0;
            triggered_q  <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            prev_q       <= prev_d;
            triggered_q  <= triggered_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Trigger configuration, only meaningful after an arm.
    always_comb begin
        cfg_pre_d   = cfg_pre_q;
        cfg_mask_d  = cfg_mask_q;
        cfg_value_d = cfg_value_q;
        cfg_mode_d  = cfg_mode_q;
        if (arm) begin
            cfg_pre_d   = pre_count;
            cfg_mask_d  = trig_mask;
            cfg_value_d = trig_value;
            cfg_mode_d  = trig_mode_e'(trig_edge);
        end
    end

    always_ff @(posedge clk) begin
        cfg_pre_q   <= cfg_pre_d;
        cfg_mask_q  <= cfg_mask_d;
        cfg_value_q <= cfg_value_d;
        cfg_mode_q  <= cfg_mode_d;
    end

    sampler_ram #(
        .width    (width),
        .addrBits (timeBits)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wp_q),
        .wr_data (w_in),
        .rd_en   (r_enable),
        .rd_addr (rd_addr),
        .rd_data (r_out)
    );

endmodule
